anb_rd_bridge: RTL and testbench
================================

Name: anb_rd_bridge

Overview:
- Slave end of the ANB read interface. Accepts one task read request (addr, len) from an ANB read master.
- Splits the request into system-memory-controller read bursts on an smc_rd_if master port, honouring the maximum burst length and an aligned address boundary.
- Buffers returned data in an internal FIFO and streams it back on the ANB data channel with a generated last.
- Sits between a DPC task engine and one client port of the SMC read arbiter.

Parameters:
- N, 4, number of SMC read clients; sets the id width clog2(N).
- CLIENT_ID, 0, id driven on smc.aid and matched against smc.id.
- MAX_LEN, 16, maximum SMC burst length in data words.
- BOUNDARY, 64, bursts never cross a BOUNDARY-word aligned address; power of 2, must be >= MAX_LEN.
- FIFO_DEPTH, 64, return-data FIFO depth in words; power of 2, must be >= MAX_LEN.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous reset, active high.
- anb  anb_rd_if.s  if  slave port. addr/len/avalid in, aready out; data/last/valid out, ready in. addr is in smc_data_t word units; len is a word count.
- smc  smc_rd_if.m  if  master port (parameter N). aid/addr/len/avalid out, aready in; id/data/strb/valid/last in, ready out.
- busy  output  1  high from request acceptance until the last ANB beat is transferred.
- err_id  output  1  sticky; set by an smc data beat whose id is not CLIENT_ID.

Behaviour:
- Reset values: anb.aready=0, anb.valid=0, anb.last=0, anb.data=0, smc.avalid=0, smc.addr=0, smc.len=0, smc.aid=CLIENT_ID, smc.ready=0, busy=0, err_id=0. FIFO is emptied and all counters are cleared.
- Reset mid-operation discards everything, including data still in flight. The SMC side must be reset in the same domain.
- FSM states:
  - IDLE: anb.aready=1. On avalid&aready, latch cur_addr=addr and rem=len, clear out_cnt, set busy. Go to ISSUE if len!=0. If len==0, stay in IDLE, drive no SMC request and no data beats; busy stays 0.
  - ISSUE: compute blen = min(rem, MAX_LEN, BOUNDARY - cur_addr[log2(BOUNDARY)-1:0]). Assert smc.avalid with addr=cur_addr, len=blen only when credit >= blen.
    - credit = FIFO_DEPTH - fifo_count - in_flight.
    - Once avalid is asserted, addr and len are held stable until aready.
    - On handshake: cur_addr += blen, rem -= blen, in_flight += blen.
    - Go to DRAIN when the new rem==0; otherwise the next burst may issue on the following cycle.
  - DRAIN: wait for the ANB beat with last=1 to handshake, then go to IDLE and drop busy.
- Earliest SMC request is the cycle after ANB address acceptance, because blen is registered.
- smc.ready=1 whenever out of reset. Credit accounting guarantees FIFO space for every own-id beat.
- Own-id beat (valid & id==CLIENT_ID): write data to the FIFO, in_flight -= 1. If an issue handshake happens in the same cycle, in_flight += blen-1.
- smc.strb and smc.last are ignored; all beats are full words.
- Foreign-id beat: dropped; err_id is set and held until reset.
- ANB data path: anb.valid = FIFO not empty. The FIFO has a registered write, so an SMC beat at cycle T is visible on anb at T+1 at the earliest.
  - anb.last = valid & (out_cnt == len_latched - 1).
  - out_cnt increments on each valid&ready.
  - Data order equals SMC return order; the SMC returns bursts of one id in order.
- anb.ready low holds data and last stable. The FIFO fills and credit goes to 0, which stalls ISSUE; no overflow is possible.
- Width rules: rem and len use task_data_len_t; cur_addr uses smc_addr_t and wraps modulo 2^width; blen and in_flight use clog2(FIFO_DEPTH)+1 bits; out_cnt uses task_data_len_t.
- Simultaneous FIFO write and read at full or empty is permitted. A read at empty is impossible because valid gates it.

Decomposition:
- bmd_mc_defs holds smc_trn_max_len_t plus the new constants SMC_TRN_MAX_LEN (default for MAX_LEN) and SMC_BURST_BOUNDARY (default for BOUNDARY).
- dpc_defs holds task_data_len_t (already present).
- One sub-module: anb_rd_fifo, a synchronous show-ahead FIFO of smc_data_t with a count output, parameterised by depth.

Test Plan:
- addr=0x10, len=5 -> one SMC burst (0x10, 5). 5 ANB beats in order, last only on beat 5, busy drops the cycle after.
- addr=0x3C, len=40 -> bursts (0x3C,4), (0x40,16), (0x50,16), (0x60,4). 40 beats, data order preserved.
- addr=0, len=200, anb.ready=0 for 500 cycles -> requested-but-undelivered words never exceed 64 and avalid stays low once credit < blen. After ready=1, all 200 words are delivered with no loss.
- Inject an SMC beat with id=2 mid-transfer (CLIENT_ID=0) -> err_id=1 next cycle and stays set. ANB stream content and count are unchanged.
- len=0 request -> accepted in one cycle, no smc.avalid, no anb.valid, aready stays 1.
- Assert rst during ISSUE with a burst in flight -> all outputs take reset values immediately. After release, a new request (0x0, 3) completes correctly.

Source files
------------

// File: rtl/anb_rd_bridge_pkg.sv
// Local types and helpers for the ANB read bridge.
package anb_rd_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } rd_state_e;

    function automatic int unsigned umin(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/bmd_mc_defs.sv
// System memory controller shared types and constants.
package bmd_mc_defs;

    localparam int unsigned SMC_ADDR_W         = 32;
    localparam int unsigned SMC_DATA_W         = 32;
    localparam int unsigned SMC_TRN_MAX_LEN    = 16;
    localparam int unsigned SMC_BURST_BOUNDARY = 64;

    typedef logic [SMC_ADDR_W-1:0]             smc_addr_t;
    typedef logic [SMC_DATA_W-1:0]             smc_data_t;
    typedef logic [SMC_DATA_W/8-1:0]           smc_strb_t;
    typedef logic [$clog2(SMC_TRN_MAX_LEN):0]  smc_trn_max_len_t;

endpackage

// File: rtl/dpc_defs.sv
// DPC task engine shared types.
package dpc_defs;

    typedef logic [15:0] task_data_len_t;

endpackage

// File: rtl/anb_rd_if.sv
// ANB read channel: one address/length request, then a data stream with last.
interface anb_rd_if;
    import bmd_mc_defs::*;
    import dpc_defs::*;

    smc_addr_t      addr;
    task_data_len_t len;
    logic           avalid;
    logic           aready;
    smc_data_t      data;
    logic           last;
    logic           valid;
    logic           ready;

    modport s (input addr, len, avalid, ready, output aready, data, last, valid);
    modport m (output addr, len, avalid, ready, input aready, data, last, valid);
endinterface

// File: rtl/smc_rd_if.sv
// SMC read client port: burst requests out, id-tagged data beats back.
interface smc_rd_if #(parameter int unsigned N = 4);
    import bmd_mc_defs::*;

    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;

    logic [IDW-1:0]   aid;
    smc_addr_t        addr;
    smc_trn_max_len_t len;
    logic             avalid;
    logic             aready;
    logic [IDW-1:0]   id;
    smc_data_t        data;
    smc_strb_t        strb;
    logic             valid;
    logic             last;
    logic             ready;

    modport m (output aid, addr, len, avalid, ready,
               input  aready, id, data, strb, valid, last);
    modport s (input  aid, addr, len, avalid, ready,
               output aready, id, data, strb, valid, last);
endinterface

// File: rtl/anb_rd_fifo.sv
// Show-ahead return-data FIFO with registered write and occupancy count.
module anb_rd_fifo
    import bmd_mc_defs::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  smc_data_t               wr_data,
    input  logic                    rd_en,
    output smc_data_t               rd_data,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int unsigned AW = $clog2(DEPTH);

    smc_data_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_en)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (count == '0);

endmodule

// File: rtl/anb_rd_bridge.sv
// ANB read slave: splits one task read into credit-limited SMC bursts and
// streams the returned words back with a generated last.
module anb_rd_bridge
    import bmd_mc_defs::*;
    import dpc_defs::*;
    import anb_rd_bridge_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned CLIENT_ID  = 0,
    parameter int unsigned MAX_LEN    = SMC_TRN_MAX_LEN,
    parameter int unsigned BOUNDARY   = SMC_BURST_BOUNDARY,
    parameter int unsigned FIFO_DEPTH = 64
) (
    input  logic   clk,
    input  logic   rst,
    anb_rd_if.s    anb,
    smc_rd_if.m    smc,
    output logic   busy,
    output logic   err_id
);
    localparam int unsigned IDW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BW  = $clog2(BOUNDARY);
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;

    rd_state_e       state;
    smc_addr_t       cur_addr;
    task_data_len_t  rem;
    task_data_len_t  len_q;
    task_data_len_t  out_cnt;
    logic [CW-1:0]   blen;
    logic [CW-1:0]   in_flight;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   credit;
    logic            aready_q;
    logic            ready_q;
    logic            fifo_empty;
    smc_data_t       fifo_data;
    logic            issue_hs;
    logic            id_match;
    logic            own_beat;
    logic            foreign_beat;
    logic            rd_en;
    logic            anb_valid;
    logic            unused_smc_fields;

    function automatic logic [CW-1:0] calc_blen(input task_data_len_t r, input smc_addr_t a);
        int unsigned b;
        b = umin(32'(r), MAX_LEN);
        b = umin(b, BOUNDARY - 32'(a[BW-1:0]));
        return CW'(b);
    endfunction

    // Words already requested count against FIFO space, so every own-id beat has a slot.
    assign credit       = CW'(FIFO_DEPTH) - fifo_count - in_flight;
    assign issue_hs     = smc.avalid & smc.aready;
    assign id_match     = (smc.id == IDW'(CLIENT_ID));
    assign own_beat     = smc.valid & ready_q & id_match;
    assign foreign_beat = smc.valid & ready_q & ~id_match;
    assign anb_valid    = ~fifo_empty;
    assign rd_en        = anb_valid & anb.ready;

    assign smc.aid    = IDW'(CLIENT_ID);
    assign smc.addr   = cur_addr;
    assign smc.len    = smc_trn_max_len_t'(blen);
    assign smc.avalid = (state == ST_ISSUE) && (credit >= blen);
    assign smc.ready  = ready_q;

    assign anb.aready = aready_q;
    assign anb.valid  = anb_valid;
    assign anb.data   = fifo_empty ? '0 : fifo_data;
    assign anb.last   = anb_valid && (out_cnt == len_q - 1'b1);

    assign unused_smc_fields = ^{smc.strb, smc.last};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            aready_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy      <= 1'b0;
            err_id    <= 1'b0;
            cur_addr  <= '0;
            rem       <= '0;
            len_q     <= '0;
            out_cnt   <= '0;
            blen      <= '0;
            in_flight <= '0;
        end else begin
            ready_q   <= 1'b1;
            in_flight <= in_flight + (issue_hs ? blen : '0) - (own_beat ? CW'(1) : '0);
            if (foreign_beat)
                err_id <= 1'b1;
            if (rd_en)
                out_cnt <= out_cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    aready_q <= 1'b1;
                    if (anb.avalid && aready_q) begin
                        cur_addr <= anb.addr;
                        rem      <= anb.len;
                        len_q    <= anb.len;
                        out_cnt  <= '0;
                        blen     <= calc_blen(anb.len, anb.addr);
                        if (anb.len != '0) begin
                            busy     <= 1'b1;
                            aready_q <= 1'b0;
                            state    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue_hs) begin
                        cur_addr <= cur_addr + smc_addr_t'(blen);
                        rem      <= rem - task_data_len_t'(blen);
                        blen     <= calc_blen(rem - task_data_len_t'(blen),
                                              cur_addr + smc_addr_t'(blen));
                        if (rem == task_data_len_t'(blen))
                            state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (rd_en && anb.last) begin
                        busy     <= 1'b0;
                        aready_q <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    anb_rd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (own_beat),
        .wr_data (smc.data),
        .rd_en   (rd_en),
        .rd_data (fifo_data),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_anb_rd_bridge.sv
// Scoreboard bench for anb_rd_bridge: random SMC memory model, random ANB
// back-pressure, expected bursts and beats derived from the splitting rules.
module tb_anb_rd_bridge;
    import bmd_mc_defs::*;
    import dpc_defs::*;

    localparam int unsigned MAXL  = 16;
    localparam int unsigned BND   = 64;
    localparam int unsigned DEPTH = 64;

    typedef struct {
        smc_data_t data;
        logic      last;
    } beat_t;

    typedef struct {
        smc_addr_t   addr;
        int unsigned len;
    } burst_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic err_id;

    anb_rd_if anb ();
    smc_rd_if #(.N(4)) smc ();

    anb_rd_bridge #(
        .N          (4),
        .CLIENT_ID  (0),
        .MAX_LEN    (MAXL),
        .BOUNDARY   (BND),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .anb    (anb),
        .smc    (smc),
        .busy   (busy),
        .err_id (err_id)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0;
    int     n_fail = 0;
    beat_t  exp_beats[$];
    burst_t exp_bursts[$];
    burst_t slv_q[$];
    int     outstanding = 0;
    int     max_out = 0;
    int     issued_words = 0;
    int     rdy_mode = 2;      // 0 random, 1 held low, 2 held high
    bit     inject = 1'b0;
    bit     inj_sent = 1'b0;

    function automatic smc_data_t data_of(input smc_addr_t a);
        return smc_data_t'(a * 32'h9E3779B1 + 32'h0BADF00D);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired, expected event did not occur", name);
    endtask

    // Reference: the word stream in address order, and the burst split rule.
    task automatic expect_req(input smc_addr_t a, input int unsigned len);
        smc_addr_t   p;
        int unsigned r;
        int unsigned b;
        int unsigned room;
        for (int unsigned i = 0; i < len; i++)
            exp_beats.push_back('{data: data_of(a + i), last: (i == len - 1)});
        p = a;
        r = len;
        while (r > 0) begin
            room = BND - (p % BND);
            b = r;
            if (b > MAXL) b = MAXL;
            if (b > room) b = room;
            exp_bursts.push_back('{addr: p, len: b});
            p = p + b;
            r = r - b;
        end
    endtask

    // Monitor: compares every SMC request and ANB beat against the queues.
    initial begin
        burst_t    eb;
        beat_t     ea;
        bit        smc_pend = 1'b0;
        smc_addr_t smc_paddr = '0;
        int        smc_plen = 0;
        bit        anb_pend = 1'b0;
        smc_data_t anb_pdata = '0;
        logic      anb_plast = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                smc_pend = 1'b0;
                anb_pend = 1'b0;
            end else begin
                if (smc_pend) begin
                    check("smc_avalid_hold", {31'b0, smc.avalid}, 32'd1);
                    check("smc_addr_hold", smc.addr, smc_paddr);
                    check("smc_len_hold", 32'(smc.len), smc_plen);
                end
                if (anb_pend) begin
                    check("anb_valid_hold", {31'b0, anb.valid}, 32'd1);
                    check("anb_data_hold", anb.data, anb_pdata);
                    check("anb_last_hold", {31'b0, anb.last}, {31'b0, anb_plast});
                end
                if (smc.avalid && smc.aready) begin
                    if (exp_bursts.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL smc_burst_unexpected: got addr %0h len %0d, expected none",
                                 smc.addr, smc.len);
                    end else begin
                        eb = exp_bursts.pop_front();
                        check("smc_burst_addr", smc.addr, eb.addr);
                        check("smc_burst_len", 32'(smc.len), eb.len);
                    end
                    outstanding  += int'(smc.len);
                    issued_words += int'(smc.len);
                    if (outstanding > max_out) max_out = outstanding;
                end
                if (anb.valid && anb.ready) begin
                    if (exp_beats.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL anb_beat_unexpected: got data %0h, expected no beat", anb.data);
                    end else begin
                        ea = exp_beats.pop_front();
                        check("anb_data", anb.data, ea.data);
                        check("anb_last", {31'b0, anb.last}, {31'b0, ea.last});
                    end
                    outstanding--;
                end
                smc_pend  = smc.avalid && !smc.aready;
                smc_paddr = smc.addr;
                smc_plen  = int'(smc.len);
                anb_pend  = anb.valid && !anb.ready;
                anb_pdata = anb.data;
                anb_plast = anb.last;
            end
        end
    end

    // ANB data-channel back-pressure.
    initial begin
        anb.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       anb.ready = ($urandom % 4) != 0;
                1:       anb.ready = 1'b0;
                default: anb.ready = 1'b1;
            endcase
        end
    end

    // SMC memory model: accepts bursts, returns words in order with gaps.
    initial begin
        bit          a_hs;
        bit          d_hs;
        bit          drove_own = 1'b0;
        smc_addr_t   cap_addr;
        int unsigned cap_len;
        int unsigned off = 0;
        smc.aready = 1'b0;
        smc.valid  = 1'b0;
        smc.id     = '0;
        smc.data   = '0;
        smc.strb   = '1;
        smc.last   = 1'b0;
        forever begin
            @(negedge clk);
            a_hs     = smc.avalid && smc.aready;
            d_hs     = smc.valid && smc.ready;
            cap_addr = smc.addr;
            cap_len  = 32'(smc.len);
            @(posedge clk);
            #1;
            if (rst) begin
                slv_q.delete();
                off        = 0;
                drove_own  = 1'b0;
                smc.valid  = 1'b0;
                smc.aready = 1'b0;
            end else begin
                if (a_hs)
                    slv_q.push_back('{addr: cap_addr, len: cap_len});
                if (d_hs && drove_own) begin
                    off++;
                    if (off == slv_q[0].len) begin
                        void'(slv_q.pop_front());
                        off = 0;
                    end
                end
                if (inject && !inj_sent) begin
                    smc.valid = 1'b1;
                    smc.id    = 2'd2;
                    smc.data  = $urandom;
                    smc.last  = 1'b0;
                    drove_own = 1'b0;
                    inj_sent  = 1'b1;
                end else if (slv_q.size() > 0 && ($urandom % 10) < 7) begin
                    smc.valid = 1'b1;
                    smc.id    = 2'd0;
                    smc.data  = data_of(slv_q[0].addr + off);
                    smc.last  = (off == slv_q[0].len - 1);
                    drove_own = 1'b1;
                end else begin
                    smc.valid = 1'b0;
                    drove_own = 1'b0;
                end
                smc.aready = ($urandom % 4) != 0;
            end
        end
    end

    task automatic send_req(input smc_addr_t a, input int unsigned len, output int unsigned waits);
        @(posedge clk);
        #1;
        expect_req(a, len);
        anb.addr   = a;
        anb.len    = task_data_len_t'(len);
        anb.avalid = 1'b1;
        waits      = 0;
        forever begin
            @(negedge clk);
            if (anb.aready) break;
            waits++;
            if (waits > 200) begin
                fail_now("anb_accept");
                break;
            end
        end
        @(posedge clk);
        #1;
        anb.avalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        forever begin
            @(negedge clk);
            if (exp_beats.size() == 0 && !busy) break;
            n++;
            if (n > 5000) begin
                fail_now(name);
                break;
            end
        end
        check({name, "_bursts_left"}, exp_bursts.size(), 32'd0);
    endtask

    initial begin
        int unsigned waits;
        int          n;
        int          viol;
        smc_addr_t   ra;
        int unsigned rl;

        anb.avalid = 1'b0;
        anb.addr   = '0;
        anb.len    = '0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aready",   {31'b0, anb.aready}, 32'd0);
        check("rst_anb_valid",{31'b0, anb.valid},  32'd0);
        check("rst_anb_last", {31'b0, anb.last},   32'd0);
        check("rst_anb_data", anb.data,            32'd0);
        check("rst_avalid",   {31'b0, smc.avalid}, 32'd0);
        check("rst_smc_addr", smc.addr,            32'd0);
        check("rst_smc_len",  32'(smc.len),        32'd0);
        check("rst_smc_aid",  32'(smc.aid),        32'd0);
        check("rst_smc_ready",{31'b0, smc.ready},  32'd0);
        check("rst_busy",     {31'b0, busy},       32'd0);
        check("rst_err_id",   {31'b0, err_id},     32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("idle_aready", {31'b0, anb.aready}, 32'd1);

        // Single burst, ready held high; busy drops right after last.
        rdy_mode = 2;
        send_req(32'h10, 5, waits);
        @(negedge clk);
        check("t1_busy_set", {31'b0, busy}, 32'd1);
        n = 0;
        forever begin
            @(negedge clk);
            if (anb.valid && anb.ready && anb.last) break;
            n++;
            if (n > 500) begin
                fail_now("t1_last");
                break;
            end
        end
        check("t1_busy_at_last", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("t1_busy_after_last", {31'b0, busy}, 32'd0);
        wait_done("t1");

        // Boundary-crossing split with random back-pressure.
        rdy_mode = 0;
        send_req(32'h3C, 40, waits);
        wait_done("t2");

        // Long stall: credit must cap outstanding words at the FIFO depth.
        rdy_mode     = 1;
        outstanding  = 0;
        max_out      = 0;
        issued_words = 0;
        send_req(32'h0, 200, waits);
        repeat (500) @(posedge clk);
        @(negedge clk);
        check("t3_max_outstanding_ok", {31'b0, (max_out <= DEPTH)}, 32'd1);
        check("t3_issued_during_stall", issued_words, DEPTH);
        check("t3_avalid_stalled", {31'b0, smc.avalid}, 32'd0);
        check("t3_anb_valid_held", {31'b0, anb.valid}, 32'd1);
        check("t3_busy", {31'b0, busy}, 32'd1);
        rdy_mode = 0;
        wait_done("t3");
        check("t3_max_outstanding_end", {31'b0, (max_out <= DEPTH)}, 32'd1);

        // Foreign-id beat mid-transfer.
        check("t4_err_before", {31'b0, err_id}, 32'd0);
        send_req(32'h100, 30, waits);
        repeat (8) @(posedge clk);
        #1;
        inj_sent = 1'b0;
        inject   = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (inj_sent) break;
            n++;
            if (n > 100) begin
                fail_now("t4_inject");
                break;
            end
        end
        check("t4_err_same_cycle", {31'b0, err_id}, 32'd0);
        @(negedge clk);
        inject = 1'b0;
        check("t4_err_next_cycle", {31'b0, err_id}, 32'd1);
        wait_done("t4");
        check("t4_err_sticky", {31'b0, err_id}, 32'd1);

        // Zero-length request: accepted at once, nothing happens.
        rdy_mode = 2;
        send_req(32'h20, 0, waits);
        check("t5_accept_waits", waits, 32'd0);
        viol = 0;
        repeat (20) begin
            @(negedge clk);
            if (smc.avalid || anb.valid || busy || !anb.aready) viol++;
        end
        check("t5_no_activity", viol, 32'd0);

        // Random requests, including an address-wrap case.
        for (int k = 0; k < 6; k++) begin
            rdy_mode = 0;
            ra = (k == 0) ? 32'hFFFF_FFF0 : $urandom;
            rl = $urandom_range(1, 90);
            send_req(ra, rl, waits);
            wait_done("rand");
        end

        // Reset while bursts are in flight.
        rdy_mode     = 0;
        issued_words = 0;
        send_req(32'h0, 150, waits);
        n = 0;
        forever begin
            @(negedge clk);
            if (issued_words > 0) break;
            n++;
            if (n > 200) begin
                fail_now("t6_first_burst");
                break;
            end
        end
        #2;
        rst = 1'b1;
        #1;
        check("t6_avalid",    {31'b0, smc.avalid}, 32'd0);
        check("t6_anb_valid", {31'b0, anb.valid},  32'd0);
        check("t6_anb_last",  {31'b0, anb.last},   32'd0);
        check("t6_anb_data",  anb.data,            32'd0);
        check("t6_aready",    {31'b0, anb.aready}, 32'd0);
        check("t6_busy",      {31'b0, busy},       32'd0);
        check("t6_smc_ready", {31'b0, smc.ready},  32'd0);
        check("t6_err_id",    {31'b0, err_id},     32'd0);
        check("t6_smc_addr",  smc.addr,            32'd0);
        check("t6_smc_len",   32'(smc.len),        32'd0);
        exp_beats.delete();
        exp_bursts.delete();
        outstanding = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        send_req(32'h0, 3, waits);
        wait_done("t6_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
